// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: shared constants, address-region and read-source encodings, counter byte helper
package mem_io_responder_pkg;
  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [2:0] IO_CLK_OFF = 3'd4;
  typedef enum logic [1:0] {REG_RAM_LO = 2'b00, REG_RAM_HI = 2'b01, REG_UNMAPPED = 2'b10, REG_IO = 2'b11} region_e;
  typedef enum logic [2:0] {SRC_RAM, SRC_RX, SRC_CNT0, SRC_CNT1, SRC_CNT2, SRC_CNT3, SRC_ZERO} src_e;
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    return w[8*k +: 8];
  endfunction
endpackage

// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if: CPU byte bus (mem_a/mem_wr/mem_dout/mem_din/io_buffer_full) plus UART tx/rx links and status flags; master=CPU/host side, slave=responder
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic mem_wr;
  logic [7:0] mem_dout;
  logic [7:0] mem_din;
  logic io_buffer_full;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_pop;
  logic prog_done;
  logic tx_ovf;
  modport master(output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
                 input mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, prog_done, tx_ovf);
  modport slave(input mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
                output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, prog_done, tx_ovf);
endinterface

// File: rtl/mem_io_tx_fifo.sv
// mem_io_tx_fifo: UART TX byte FIFO; ports clk_in/rst_n_in, push/push_data, pop, drop -> registered tx_data/tx_valid/near_full, sticky ovf, count
module mem_io_tx_fifo #(
  parameter int TX_DEPTH = 8,
  parameter int FULL_MARGIN = 2,
  localparam int PW = $clog2(TX_DEPTH),
  localparam int CW = $clog2(TX_DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  input  logic          drop,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  output logic          near_full,
  output logic          ovf,
  output logic [CW-1:0] count
);
  logic [7:0] mem_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_valid_q, tx_valid_d, near_full_q, near_full_d, ovf_q, ovf_d;
  logic do_pop, do_push;
  always_comb begin
    do_pop = pop & (count_q != '0);
    do_push = push & ((count_q != CW'(TX_DEPTH)) | do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    tx_valid_d = count_d != '0;
    tx_data_d = (do_push && wr_ptr_q == rd_ptr_d) ? push_data : mem_q[rd_ptr_d];
    near_full_d = count_d >= CW'(TX_DEPTH - FULL_MARGIN);
    ovf_d = ovf_q | drop | (push & ~do_push);
  end
  always_ff @(posedge clk_in)
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      near_full_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      near_full_q <= near_full_d;
      ovf_q <= ovf_d;
    end
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign near_full = near_full_q;
  assign ovf = ovf_q;
  assign count = count_q;
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus RAM + memory-mapped UART/cycle counter; ports clk_in, rst_n_in, bus (slave); optional MEM_IO_CLK_SNAPSHOT_EN
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH = 8,
  parameter int FULL_MARGIN = 2,
  localparam int CW = $clog2(TX_DEPTH + 1)
) (
  input logic clk_in,
  input logic rst_n_in,
  mem_io_responder_if.slave bus
);
  logic [7:0] ram_q [2**RAM_ADDR_W];
  logic [7:0] ram_rd_q, rx_q, rx_d, skid_q, skid_d, push_data;
  logic [31:0] cnt_q, cnt_d, cnt_rd_q, cnt_rd_d;
  src_e sel_q, sel_d, src;
  region_e region;
  logic [2:0] off;
  logic [CW-1:0] fifo_count;
  logic prog_done_q, prog_done_d, done_pend_q, done_pend_d, skid_v_q, skid_v_d;
  logic is_ram, is_io, rd, uart_wr, stop_wr, done_req, space, push, drop, pop, unused_hi;
`ifdef MEM_IO_CLK_SNAPSHOT_EN
  logic [31:0] snap_q, snap_d;
`endif
  always_comb begin
    region = region_e'(bus.mem_a[17:16]);
    off = bus.mem_a[2:0];
    is_ram = region == REG_RAM_LO || region == REG_RAM_HI;
    is_io = bus.mem_a[17:16] == IO_BASE[17:16];
    rd = ~bus.mem_wr;
    uart_wr = bus.mem_wr & is_io & (off == 3'd0) & (bus.mem_dout != '0);
    stop_wr = bus.mem_wr & is_io & (off == IO_CLK_OFF);
    src = is_ram ? SRC_RAM : !is_io ? SRC_ZERO : off == 3'd0 ? (bus.rx_valid ? SRC_RX : SRC_ZERO) :
          off[2] ? src_e'(3'(SRC_CNT0) + 3'(off[1:0])) : SRC_ZERO;
    sel_d = rd ? src : sel_q;
    rx_d = rd ? bus.rx_data : rx_q;
    cnt_d = cnt_q + 32'd1;
`ifdef MEM_IO_CLK_SNAPSHOT_EN
    snap_d = (rd && is_io && off == IO_CLK_OFF) ? cnt_q : snap_q;
    cnt_rd_d = rd ? (off == IO_CLK_OFF ? cnt_q : snap_q) : cnt_rd_q;
`else
    cnt_rd_d = rd ? cnt_q : cnt_rd_q;
`endif
    pop = bus.tx_valid & bus.tx_ready;
    done_req = done_pend_q | stop_wr;
    space = (fifo_count != CW'(TX_DEPTH)) | pop;
    push = done_req ? space : (skid_v_q | uart_wr);
    push_data = done_req ? 8'h00 : skid_v_q ? skid_q : bus.mem_dout;
    done_pend_d = done_req & ~space;
    skid_v_d = done_req ? (skid_v_q | uart_wr) : (skid_v_q & uart_wr);
    skid_d = (uart_wr & (done_req ^ skid_v_q)) ? bus.mem_dout : skid_q;
    drop = done_req & skid_v_q & uart_wr;
    prog_done_d = prog_done_q | stop_wr;
  end
  always_ff @(posedge clk_in)
    if (bus.mem_wr) begin
      if (is_ram) ram_q[bus.mem_a[RAM_ADDR_W-1:0]] <= bus.mem_dout;
    end else ram_rd_q <= ram_q[bus.mem_a[RAM_ADDR_W-1:0]];
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      sel_q <= SRC_ZERO;
      rx_q <= '0;
      cnt_q <= '0;
      cnt_rd_q <= '0;
      prog_done_q <= 1'b0;
      done_pend_q <= 1'b0;
      skid_v_q <= 1'b0;
      skid_q <= '0;
`ifdef MEM_IO_CLK_SNAPSHOT_EN
      snap_q <= '0;
`endif
    end else begin
      sel_q <= sel_d;
      rx_q <= rx_d;
      cnt_q <= cnt_d;
      cnt_rd_q <= cnt_rd_d;
      prog_done_q <= prog_done_d;
      done_pend_q <= done_pend_d;
      skid_v_q <= skid_v_d;
      skid_q <= skid_d;
`ifdef MEM_IO_CLK_SNAPSHOT_EN
      snap_q <= snap_d;
`endif
    end
  mem_io_tx_fifo #(.TX_DEPTH(TX_DEPTH), .FULL_MARGIN(FULL_MARGIN)) u_fifo (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .push(push),
    .push_data(push_data),
    .pop(pop),
    .drop(drop),
    .tx_data(bus.tx_data),
    .tx_valid(bus.tx_valid),
    .near_full(bus.io_buffer_full),
    .ovf(bus.tx_ovf),
    .count(fifo_count)
  );
  assign bus.mem_din = sel_q == SRC_RAM ? ram_rd_q : sel_q == SRC_RX ? rx_q : sel_q == SRC_ZERO ? 8'h00 :
                       byte_of(cnt_rd_q, 2'(3'(sel_q) - 3'(SRC_CNT0)));
  assign bus.rx_pop = rst_n_in & rd & is_io & (off == 3'd0) & bus.rx_valid;
  assign bus.prog_done = prog_done_q;
  assign unused_hi = ^bus.mem_a[31:18];
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed and randomized checks of mem_io_responder against a queue-based reference model
module tb_mem_io_responder;
  localparam int DEPTH = 8;
  localparam int MARGIN = 2;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  int checks = 0;
  int failures = 0;
  mem_io_responder_if bus();
  mem_io_responder #(.RAM_ADDR_W(17), .TX_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  logic [7:0] ram_m [int];
  logic [7:0] q_m[$];
  logic [7:0] skid_m[$];
  logic [7:0] sent[$];
  logic pend_m, ovf_m, done_m, din_known;
  logic [7:0] din_m;
  logic [31:0] cyc_m, snap_m;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    q_m.delete();
    skid_m.delete();
    pend_m = 1'b0;
    ovf_m = 1'b0;
    done_m = 1'b0;
    cyc_m = 32'd0;
    snap_m = 32'd0;
    din_m = 8'h00;
    din_known = 1'b1;
  endtask
  task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d);
    logic io, rdk, pop, uart_wr, stop_wr, done_req;
    logic [2:0] off;
    logic [7:0] rdv, b;
    bus.mem_a = a;
    bus.mem_wr = wr;
    bus.mem_dout = d;
    io = a[17:16] == 2'b11;
    off = a[2:0];
    #1;
    chk("rx_pop", bus.rx_pop, !wr && io && off == 3'd0 && bus.rx_valid);
    if (bus.tx_valid && bus.tx_ready) sent.push_back(bus.tx_data);
    rdk = 1'b1;
    rdv = 8'h00;
    if (!a[17]) begin
      rdk = ram_m.exists(int'(a[16:0]));
      if (rdk) rdv = ram_m[int'(a[16:0])];
    end else if (io && off == 3'd0) rdv = bus.rx_valid ? bus.rx_data : 8'h00;
`ifdef MEM_IO_CLK_SNAPSHOT_EN
    else if (io && off[2]) rdv = off == 3'd4 ? cyc_m[7:0] : 8'(snap_m >> (8 * off[1:0]));
`else
    else if (io && off[2]) rdv = 8'(cyc_m >> (8 * off[1:0]));
`endif
    uart_wr = wr && io && off == 3'd0 && d != 8'h00;
    stop_wr = wr && io && off == 3'd4;
    pop = q_m.size() != 0 && bus.tx_ready;
    @(posedge clk_in);
    if (pop) void'(q_m.pop_front());
    done_req = pend_m || stop_wr;
    if (done_req) begin
      pend_m = q_m.size() >= DEPTH;
      if (!pend_m) q_m.push_back(8'h00);
      if (uart_wr) begin
        if (skid_m.size() != 0) ovf_m = 1'b1;
        else skid_m.push_back(d);
      end
    end else begin
      if (uart_wr) skid_m.push_back(d);
      if (skid_m.size() != 0) begin
        b = skid_m.pop_front();
        if (q_m.size() < DEPTH) q_m.push_back(b);
        else ovf_m = 1'b1;
      end
    end
    done_m = done_m | stop_wr;
    if (wr && !a[17]) ram_m[int'(a[16:0])] = d;
    if (!wr) begin
      din_m = rdv;
      din_known = rdk;
    end
`ifdef MEM_IO_CLK_SNAPSHOT_EN
    if (!wr && io && off == 3'd4) snap_m = cyc_m;
`endif
    cyc_m++;
    @(negedge clk_in);
    if (din_known) chk("mem_din", bus.mem_din, din_m);
    chk("tx_valid", bus.tx_valid, q_m.size() != 0);
    if (q_m.size() != 0) chk("tx_data", bus.tx_data, q_m[0]);
    chk("io_full", bus.io_buffer_full, q_m.size() >= DEPTH - MARGIN);
    chk("tx_ovf", bus.tx_ovf, ovf_m);
    chk("prog_done", bus.prog_done, done_m);
  endtask
  task automatic idle(input int n);
    repeat (n) step(32'h20000, 1'b0, 8'h00);
  endtask
  task automatic do_reset();
    rst_n_in = 1'b0;
    #1;
    chk("rst_prog_done", bus.prog_done, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    repeat (2) @(negedge clk_in);
    model_reset();
    rst_n_in = 1'b1;
    chk("rst_mem_din", bus.mem_din, 0);
    chk("rst_io_full", bus.io_buffer_full, 0);
    chk("rst_tx_ovf", bus.tx_ovf, 0);
  endtask
  function automatic logic [31:0] ram_addr(input logic [3:0] i);
    return (i[0] ? 32'h10000 : 32'h0) | (32'(i) * 32'h111);
  endfunction
  function automatic logic [31:0] rnd_addr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) return (r & 32'hFFFC0000) | ram_addr(r[3:0]);
    if (k == 4) return (r & ~32'h30000) | 32'h20000;
    return (r & ~32'h30000) | 32'h30000;
  endfunction
  initial begin
    bus.mem_a = 32'h20000;
    bus.mem_wr = 1'b0;
    bus.mem_dout = 8'h00;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    @(negedge clk_in);
    do_reset();
    step(32'h10, 1'b1, 8'hA5);
    step(32'h10, 1'b0, 8'h00);
    chk("ram_rt", bus.mem_din, 8'hA5);
    step(32'h20010, 1'b0, 8'h00);
    chk("unmapped_rd", bus.mem_din, 8'h00);
    bus.tx_ready = 1'b1;
    sent.delete();
    step(32'h30000, 1'b1, 8'h41);
    step(32'h30000, 1'b1, 8'h00);
    step(32'h30000, 1'b1, 8'h42);
    idle(4);
    chk("filt_n", sent.size(), 2);
    chk("filt_0", sent[0], 8'h41);
    chk("filt_1", sent[1], 8'h42);
    bus.tx_ready = 1'b0;
    sent.delete();
    for (int i = 0; i < 6; i++) step(32'h30000, 1'b1, 8'(8'h10 + i));
    chk("full_at6", bus.io_buffer_full, 1);
    for (int i = 6; i < 9; i++) step(32'h30000, 1'b1, 8'(8'h10 + i));
    chk("ovf_9th", bus.tx_ovf, 1);
    bus.tx_ready = 1'b1;
    idle(10);
    chk("drain_n", sent.size(), 8);
    for (int i = 0; i < 8; i++) chk("drain_ord", sent[i], 32'(8'h10 + i));
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h37;
    step(32'h30000, 1'b0, 8'h00);
    chk("rx_rd", bus.mem_din, 8'h37);
    bus.rx_valid = 1'b0;
    step(32'h30000, 1'b0, 8'h00);
    chk("rx_empty", bus.mem_din, 8'h00);
    bus.tx_ready = 1'b0;
    sent.delete();
    for (int i = 0; i < 8; i++) step(32'h30000, 1'b1, 8'(8'h20 + i));
    step(32'h30004, 1'b1, 8'h55);
    chk("stop_done", bus.prog_done, 1);
    bus.tx_ready = 1'b1;
    idle(12);
    chk("stop_n", sent.size(), 9);
    chk("stop_zero", sent[8], 8'h00);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(32'h30000, 1'b1, 8'(8'h60 + i));
    do_reset();
    idle(100);
    step(32'h30004, 1'b0, 8'h00);
    chk("cnt_b0", bus.mem_din, 8'h64);
    step(32'h30005, 1'b0, 8'h00);
    chk("cnt_b1", bus.mem_din, 8'h00);
    step(32'h30006, 1'b0, 8'h00);
    chk("cnt_b2", bus.mem_din, 8'h00);
    step(32'h30007, 1'b0, 8'h00);
    chk("cnt_b3", bus.mem_din, 8'h00);
    for (int i = 0; i < 16; i++) step(ram_addr(4'(i)), 1'b1, 8'($urandom));
    for (int s = 0; s < 3; s++) begin
      do_reset();
      for (int i = 0; i < 1000; i++) begin
        bus.tx_ready = $urandom_range(0, 3) < (s == 1 ? 3 : 1);
        bus.rx_valid = 1'($urandom_range(0, 1));
        bus.rx_data = 8'($urandom);
        step(rnd_addr(), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom));
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU byte bus (address, data-out, data-in, write strobe, io_buffer_full).
- Contains the 128KB byte RAM, the memory-mapped I/O at 0x30000/0x30004, a free-running cycle counter, a UART TX FIFO and an RX byte path.
- Sits between the cpu top and the UART/host links and drives the CPU's mem_din and io_buffer_full.

Parameters:
- RAM_ADDR_W, 17, RAM byte-address width (2^17 bytes).
- TX_DEPTH, 8, TX FIFO entries (power of two).
- FULL_MARGIN, 2, free-entry threshold for io_buffer_full, covering CPU writes already in flight.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- mem_a  input  32  CPU address; only bits 17:0 are decoded.
- mem_wr  input  1  1 = write, 0 = read.
- mem_dout  input  8  CPU write data.
- mem_din  output  8  read data, valid one cycle after the address.
- io_buffer_full  output  1  TX FIFO near full.
- tx_data  output  8  UART TX byte.
- tx_valid  output  1  TX byte available.
- tx_ready  input  1  UART accepts the byte on valid&ready.
- rx_data  input  8  UART RX byte.
- rx_valid  input  1  RX byte present.
- rx_pop  output  1  one-cycle pulse consuming rx_data.
- prog_done  output  1  sticky program-stop flag.
- tx_ovf  output  1  sticky TX overflow flag.

Behaviour:
- Reset (async, rst_n_in=0) clears: mem_din=0, tx_valid=0, rx_pop=0, prog_done=0, tx_ovf=0, io_buffer_full=0, FIFO pointers/count, cycle counter, snapshot, done_pend. RAM contents are not reset.
- Decode uses mem_a[17:16]:
  - 00, 01 = RAM, index mem_a[16:0].
  - 10 = unmapped: reads return 0x00, writes are ignored.
  - 11 = I/O, selected by mem_a[2:0]. Offset 0 = UART, offset 4..7 = counter bytes, other offsets read 0.
- RAM write: when mem_wr=1 in cycle t, the byte is stored at the clock edge; a read in t+1 sees it.
- Read: with mem_wr=0 in cycle t, mem_din in t+1 holds the selected byte. The source select is registered in t and the RAM is a synchronous read.
- Write cycles: mem_din holds its previous value.
- Cycle counter: 32-bit, +1 every cycle from reset, wraps 0xFFFFFFFF→0. Byte k of it is returned for offset 4+k (little-endian).
- UART read (0x30000):
  - if rx_valid in t: mem_din=rx_data in t+1, rx_pop pulses in t.
  - else mem_din=0x00 in t+1 and there is no pop.
- UART write (0x30000): a non-zero byte is pushed into the TX FIFO; 0x00 is ignored.
- Stop write (0x30004, any data):
  - prog_done=1 next cycle.
  - a 0x00 byte is pushed into the TX FIFO (the zero filter does not apply). If the FIFO is full, done_pend holds the push until space is free.
- TX FIFO:
  - count is 0..TX_DEPTH; pointers wrap modulo TX_DEPTH.
  - a push and a pop in the same cycle leave count unchanged; this holds at full and at empty.
  - tx_valid = (count≠0) and tx_data = head entry, both registered outputs.
  - io_buffer_full = (count ≥ TX_DEPTH−FULL_MARGIN), registered.
  - a push when count==TX_DEPTH with no simultaneous pop drops the byte and sets tx_ovf (sticky until reset).
  - a pending done push has priority over a CPU push in the same cycle; the CPU byte goes next cycle via a 1-entry skid, and a second collision overflows.
- Reset mid-operation: all queued bytes are discarded and prog_done clears.

Optional Feature:
- Macro MEM_IO_CLK_SNAPSHOT_EN.
- Defined:
  - a read of 0x30004 returns live byte 0 and latches the full 32-bit counter into a snapshot.
  - reads of 0x30005..0x30007 return snapshot bytes, giving a coherent 4-byte read.
  - the snapshot is 0 after reset.
- Undefined: every offset returns the live counter byte at the read cycle and there is no snapshot register.

Decomposition:
- Shared package/def file holds:
  - IO_BASE=0x30000 and IO_CLK_OFF=4.
  - the address-region encoding (RAM/UNMAPPED/IO) and the read-source select enum (RAM, RX, CNT0..3, ZERO).
- Sub-module mem_io_tx_fifo: parameterised by TX_DEPTH/FULL_MARGIN; provides push/pop/count/near_full/ovf.
- RAM: inferred inline as a synchronous-read byte array.

Test Plan:
- RAM round trip: write 0xA5 @0x00010, then read @0x00010 → mem_din=0xA5 exactly one cycle after the read address; read @0x20010 → 0x00.
- UART write filter: write 0x41, 0x00, 0x42 @0x30000 with tx_ready=1 → tx_data emits exactly 0x41 then 0x42, with no 0x00.
- TX full (TX_DEPTH=8, FULL_MARGIN=2):
  - tx_ready=0, push 6 bytes → io_buffer_full=1 after the 6th.
  - 3 more pushes → 9th dropped, tx_ovf=1.
  - release tx_ready → 8 bytes out in order.
- RX read: rx_valid=1, rx_data=0x37, read 0x30000 → rx_pop pulse same cycle, mem_din=0x37 next cycle. With rx_valid=0 → mem_din=0x00 and no pop.
- Stop: write @0x30004 while FIFO full → prog_done=1 next cycle; 0x00 emitted once space frees; async reset mid-stream → prog_done=0, tx_valid=0 immediately.
- Counter: 100 cycles after reset, read 0x30004..0x30007 on consecutive cycles:
  - with MEM_IO_CLK_SNAPSHOT_EN → bytes 0x64,0,0,0 (count at first read).
  - without it → byte0=0x64 and the live upper bytes.
